// File: rtl/output_deskew.sv
// Output deskew for the pipelined DDSM datapath: per-lane delay lines undo the
// entry skew, then one register stage emits the aligned {msb,isb,lsb} word.

module deskew_lane #(
    parameter int P_WIDTH = 8,
    parameter int P_DELAY = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] din,
    input  logic               vld_in,
    output logic [P_WIDTH-1:0] dout,
    output logic               vld_out
);
    generate
        if (P_DELAY == 0) begin : g_pass
            assign dout    = din;
            assign vld_out = vld_in;
        end else begin : g_dly
            logic [P_DELAY:1][P_WIDTH-1:0] data_pipe;
            logic [P_DELAY:1]              vld_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_pipe <= '0;
                    vld_pipe  <= '0;
                end else begin
                    data_pipe[1] <= din;
                    vld_pipe[1]  <= vld_in;
                    for (int s = 2; s <= P_DELAY; s++) begin
                        data_pipe[s] <= data_pipe[s-1];
                        vld_pipe[s]  <= vld_pipe[s-1];
                    end
                end
            end

            assign dout    = data_pipe[P_DELAY];
            assign vld_out = vld_pipe[P_DELAY];
        end
    endgenerate
endmodule

module output_deskew #(
    parameter int P_WIDTH     = 8,
    parameter int P_MSB_DELAY = 0,
    parameter int P_ISB_DELAY = 2,
    parameter int P_LSB_DELAY = 4,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [P_WIDTH-1:0]     i_msb,
    input  logic                   i_msb_vld,
    input  logic [P_WIDTH-1:0]     i_isb,
    input  logic                   i_isb_vld,
    input  logic [P_WIDTH-1:0]     i_lsb,
    input  logic                   i_lsb_vld,
    input  logic                   i_clr,
    output logic [3*P_WIDTH-1:0]   o_word,
    output logic                   o_vld,
    output logic                   o_align_err,
    output logic [P_CNT_WIDTH-1:0] o_cnt
);
    localparam int NUM_LANES = 3;

    // Lane index 2/1/0 = msb/isb/lsb so the packed array is already the output word.
    logic [NUM_LANES-1:0][P_WIDTH-1:0] lane_in, lane_dly;
    logic [NUM_LANES-1:0]              vld_in, vld_dly;

    assign lane_in = {i_msb, i_isb, i_lsb};
    assign vld_in  = {i_msb_vld, i_isb_vld, i_lsb_vld};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            localparam int D = (g == 2) ? P_MSB_DELAY :
                               (g == 1) ? P_ISB_DELAY : P_LSB_DELAY;
            if (D < 0 || D > 15) begin : g_bad_delay
                $error("output_deskew: lane delay out of range 0..15");
            end
            deskew_lane #(.P_WIDTH(P_WIDTH), .P_DELAY(D)) u_lane (
                .clk     (i_clk),
                .rst_n   (i_rst_n),
                .din     (lane_in[g]),
                .vld_in  (vld_in[g]),
                .dout    (lane_dly[g]),
                .vld_out (vld_dly[g])
            );
        end
    endgenerate

    logic all_vld, misaligned;
    assign all_vld    = &vld_dly;
    assign misaligned = (|vld_dly) & ~all_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word <= '0;
            o_vld  <= 1'b0;
        end else begin
            o_word <= lane_dly;
            o_vld  <= all_vld;
        end
    end

    // Clear beats a coincident set/increment; counter counts registered o_vld.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_align_err <= 1'b0;
            o_cnt       <= '0;
        end else if (i_clr) begin
            o_align_err <= 1'b0;
            o_cnt       <= '0;
        end else begin
            if (misaligned)
                o_align_err <= 1'b1;
            if (o_vld && (o_cnt != {P_CNT_WIDTH{1'b1}}))
                o_cnt <= o_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_output_deskew.sv
// Bench for output_deskew: default instance plus a zero-skew, 4-bit-counter
// instance, both checked against a cycle-history reference model.

module tb_output_deskew;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  din [3];
    logic        vin [3];

    logic [23:0] word0, word1;
    logic        vld0, vld1, err0, err1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    output_deskew dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_msb(din[2]), .i_msb_vld(vin[2]),
        .i_isb(din[1]), .i_isb_vld(vin[1]),
        .i_lsb(din[0]), .i_lsb_vld(vin[0]),
        .i_clr(clr),
        .o_word(word0), .o_vld(vld0), .o_align_err(err0), .o_cnt(cnt0)
    );

    output_deskew #(.P_ISB_DELAY(0), .P_LSB_DELAY(0), .P_CNT_WIDTH(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_msb(din[2]), .i_msb_vld(vin[2]),
        .i_isb(din[1]), .i_isb_vld(vin[1]),
        .i_lsb(din[0]), .i_lsb_vld(vin[0]),
        .i_clr(clr),
        .o_word(word1), .o_vld(vld1), .o_align_err(err1), .o_cnt(cnt1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // History of what each lane presented at every clock edge (zero while in reset).
    bit [7:0]    h_data [3][MAXC];
    bit          h_vld  [3][MAXC];
    int          dly  [2][3] = '{'{4, 2, 0}, '{0, 0, 0}};
    int          cmax [2]    = '{65535, 15};
    bit          m_vld [2];
    bit          m_err [2];
    int          m_cnt [2];
    logic [23:0] m_word [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int l = 0; l < 3; l++) begin
            h_vld[l][cyc]  = rst_n && vin[l];
            h_data[l][cyc] = rst_n ? din[l] : 8'h00;
        end
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_vld[d] = 0; m_err[d] = 0; m_cnt[d] = 0; m_word[d] = '0;
            end else begin
                bit all_v;
                bit any_v;
                int idx;
                int n_cnt;
                bit v;
                logic [23:0] w;
                all_v = 1; any_v = 0; w = '0;
                for (int l = 0; l < 3; l++) begin
                    idx = cyc - dly[d][l];
                    v = (idx >= 0) ? h_vld[l][idx] : 1'b0;
                    w[l*8 +: 8] = (idx >= 0) ? h_data[l][idx] : 8'h00;
                    all_v = all_v & v;
                    any_v = any_v | v;
                end
                if (clr) n_cnt = 0;
                else if (m_vld[d] && m_cnt[d] < cmax[d]) n_cnt = m_cnt[d] + 1;
                else n_cnt = m_cnt[d];
                m_err[d] = clr ? 1'b0 : (m_err[d] | (any_v & ~all_v));
                m_cnt[d] = n_cnt;
                m_vld[d] = all_v;
                m_word[d] = w;
            end
        end
        cyc++;
        #1;
        chk("vld0", vld0, m_vld[0]);
        chk("err0", err0, m_err[0]);
        chk("cnt0", cnt0, m_cnt[0]);
        if (m_vld[0] || !rst_n) chk("word0", word0, m_word[0]);
        chk("vld1", vld1, m_vld[1]);
        chk("err1", err1, m_err[1]);
        chk("cnt1", cnt1, m_cnt[1]);
        if (m_vld[1] || !rst_n) chk("word1", word1, m_word[1]);
    endtask

    task automatic idle(int n);
        for (int l = 0; l < 3; l++) vin[l] = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_pulse();
        clr = 1; step(); clr = 0;
    endtask

    task automatic rand_all_vld();
        for (int l = 0; l < 3; l++) begin
            din[l] = 8'($urandom);
            vin[l] = 1;
        end
    endtask

    initial begin
        for (int l = 0; l < 3; l++) begin din[l] = 0; vin[l] = 0; end

        // Reset held with live valid traffic, then released mid-stream
        for (int i = 0; i < 5; i++) begin rand_all_vld(); step(); end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            rand_all_vld(); step();
            chk("post_rst_vld0", vld0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin rand_all_vld(); step(); end
        idle(6);
        clr_pulse();

        // Single skewed sample
        vin[0] = 1; din[0] = 8'h11; step();
        vin[0] = 0; step();
        vin[1] = 1; din[1] = 8'h22; step();
        vin[1] = 0; step();
        vin[2] = 1; din[2] = 8'h33; step();
        chk("single_word", word0, 24'h332211);
        chk("single_vld", vld0, 1'b1);
        vin[2] = 0; step();
        chk("single_vld_off", vld0, 1'b0);
        chk("single_err", err0, 1'b0);
        idle(6);
        clr_pulse();

        // 100-sample skewed stream
        for (int t = 0; t < 104; t++) begin
            vin[0] = (t < 100);            din[0] = 8'(t);
            vin[1] = (t >= 2 && t < 102);  din[1] = 8'(t - 1);
            vin[2] = (t >= 4);             din[2] = 8'(t - 2);
            step();
        end
        idle(3);
        chk("stream_cnt", cnt0, 16'd100);
        chk("stream_err", err0, 1'b0);
        clr_pulse();

        // isb one cycle late
        vin[0] = 1; din[0] = 8'h5a; step();
        idle(2);
        vin[1] = 1; din[1] = 8'ha5; step();
        vin[1] = 0; vin[2] = 1; din[2] = 8'h3c; step();
        idle(6);
        chk("mis_err_sticky", err0, 1'b1);
        clr_pulse();
        step();
        chk("mis_err_clr", err0, 1'b0);

        // Continuous aligned stream: saturation and clear-wins on a valid cycle
        for (int i = 0; i < 25; i++) begin
            rand_all_vld();
            clr = (i == 20);
            step();
            if (i == 19) chk("sat_cnt1", cnt1, 4'd15);
            if (i == 20) chk("sat_clr_cnt1", cnt1, 4'd0);
            if (i == 21) chk("sat_resume_cnt1", cnt1, 4'd1);
        end
        clr = 0;
        idle(6);
        clr_pulse();

        // Random valid patterns and occasional clears
        for (int i = 0; i < 40; i++) begin
            for (int l = 0; l < 3; l++) begin
                din[l] = 8'($urandom);
                vin[l] = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 15) == 0);
            step();
        end
        clr = 0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
